// File: rtl/mem_uart_resp.sv
// Byte-stream memory access responder: decodes 7-bit-safe command frames from a
// UART receive stream, issues one memory read or write, and streams read data back.
module mem_uart_resp #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_re,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on any rising edge where valid & ready are both high;
    // a producer holds valid and data steady until that edge.

    localparam logic [2:0] S_CMD   = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_AMSB  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_WMSB  = 3'd4;
    localparam logic [2:0] S_MEM   = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  len_q, len_d;
    logic        is_read_q, is_read_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        rx_fire, tx_fire;

    assign rx_ready  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_AMSB)
                    || (state_q == S_WDATA) || (state_q == S_WMSB);
    assign tx_valid  = (state_q == S_RESP);
    assign tx_data   = rdata_q[{cnt_q, 3'b000} +: 8];
    assign rx_fire   = rx_valid & rx_ready;
    assign tx_fire   = tx_valid & tx_ready;
    assign mem_addr  = addr_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign busy      = (state_q != S_CMD);
    assign err       = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_d      = be_q;
        re_d      = re_q;
        we_d      = we_q;
        err_d     = 1'b0;
        case (state_q)
            S_CMD: begin
                if (rx_fire) begin
                    if (rx_data[7:2] == 6'b110000 || rx_data[7:2] == 6'b100000) begin
                        is_read_d = rx_data[6];
                        len_d     = rx_data[1:0];
                        cnt_d     = 2'd0;
                        addr_d    = 32'd0;
                        wdata_d   = 32'd0;
                        case (rx_data[1:0])
                            2'd0:    be_d = 4'b0001;
                            2'd1:    be_d = 4'b0011;
                            2'd2:    be_d = 4'b0111;
                            default: be_d = 4'b1111;
                        endcase
                        state_d = S_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d[{cnt_q, 3'b000} +: 7] = rx_data[6:0];
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_AMSB;
                end
            end
            S_AMSB: begin
                if (rx_fire) begin
                    addr_d[7]  = rx_data[0];
                    addr_d[15] = rx_data[1];
                    addr_d[23] = rx_data[2];
                    addr_d[31] = rx_data[3];
                    cnt_d      = 2'd0;
                    if (is_read_q) begin
                        state_d = S_MEM;
                        re_d    = 1'b1;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (rx_fire) begin
                    wdata_d[{cnt_q, 3'b000} +: 7] = rx_data[6:0];
                    if (cnt_q == len_q) begin
                        state_d = S_WMSB;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_WMSB: begin
                if (rx_fire) begin
                    // Bytes above len stay zero, so their MSB bits are dropped.
                    wdata_d[7] = rx_data[0];
                    if (len_q >= 2'd1) wdata_d[15] = rx_data[1];
                    if (len_q >= 2'd2) wdata_d[23] = rx_data[2];
                    if (len_q == 2'd3) wdata_d[31] = rx_data[3];
                    state_d = S_MEM;
                    we_d    = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    re_d = 1'b0;
                    we_d = 1'b0;
                    if (is_read_q) begin
                        rdata_d = mem_rdata;
                        cnt_d   = 2'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_CMD;
                    end
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = 2'd0;
                        state_d = S_CMD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CMD;
            cnt_q     <= 2'd0;
            len_q     <= 2'd0;
            is_read_q <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            be_q      <= 4'd0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            be_q      <= be_d;
            re_q      <= re_d;
            we_q      <= we_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_uart_resp.sv
// Directed bench for mem_uart_resp: frames are pushed byte by byte, a hand-driven
// memory responder answers strobes, and returned bytes are checked against constants.
module tb_mem_uart_resp;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;
    logic [2:0]  dbg_state;

    int tests_run;
    int tests_failed;

    mem_uart_resp #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: present one byte and hold it until the DUT takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            tests_failed++;
            $display("FAIL rx_accept: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Memory responder: wait for a strobe, check request fields, hold, then ack.
    task automatic serve_mem(input logic exp_we, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                             input logic [31:0] rdata);
        int n;
        n = 0;
        while (mem_re !== 1'b1 && mem_we !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n >= 20) begin
            tests_failed++;
            $display("FAIL mem_strobe: no strobe seen, re=%b we=%b", mem_re, mem_we);
        end
        tests_run++;
        if (mem_we !== exp_we || mem_re !== !exp_we) begin
            tests_failed++;
            $display("FAIL mem_kind: re=%b we=%b required re=%b we=%b", mem_re, mem_we, !exp_we, exp_we);
        end
        tests_run++;
        if (mem_addr !== exp_addr || mem_be !== exp_be) begin
            tests_failed++;
            $display("FAIL mem_req: addr=%h be=%b required addr=%h be=%b", mem_addr, mem_be, exp_addr, exp_be);
        end
        if (exp_we) begin
            tests_run++;
            if (mem_wdata !== exp_wdata) begin
                tests_failed++;
                $display("FAIL mem_wdata: got %h required %h", mem_wdata, exp_wdata);
            end
        end
        repeat (2) begin
            @(posedge clk); #1;
            tests_run++;
            if (mem_addr !== exp_addr || mem_be !== exp_be || (mem_re | mem_we) !== 1'b1
                || (exp_we && mem_wdata !== exp_wdata)) begin
                tests_failed++;
                $display("FAIL mem_stable: addr=%h be=%b wdata=%h re=%b we=%b required addr=%h be=%b",
                         mem_addr, mem_be, mem_wdata, mem_re, mem_we, exp_addr, exp_be);
            end
        end
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        tests_run++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_drop: re=%b we=%b required 0 0 after ack", mem_re, mem_we);
        end
    endtask

    // Transmit sink: check one response byte, optionally stalling tx_ready.
    task automatic recv_tx(input logic [7:0] exp, input int stall);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== exp) begin
            tests_failed++;
            $display("FAIL tx_byte: valid=%b data=%h required valid=1 data=%h", tx_valid, tx_data, exp);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                tests_failed++;
                $display("FAIL tx_hold: cycle %0d valid=%b data=%h required valid=1 data=%h", i, tx_valid, tx_data, exp);
            end
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0
            || err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: rx_ready=%b tx_valid=%b re=%b we=%b err=%b busy=%b required 1 0 0 0 0 0",
                     rx_ready, tx_valid, mem_re, mem_we, err, busy);
        end
        tests_run++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0 || tx_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%b tx_data=%h required all zero",
                     mem_addr, mem_wdata, mem_be, tx_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_word();
        logic [7:0] frame [11];
        frame = '{8'h83, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h6F, 8'h3E, 8'h2D, 8'h5E, 8'h0F};
        for (int i = 0; i < 11; i++) send_byte(frame[i]);
        serve_mem(1'b1, 32'h0000_1080, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (tx_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_no_tx: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_read_byte();
        logic [7:0] frame [6];
        frame = '{8'hC0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        tests_run++;
        if (rx_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_mem_state: rx_ready=%b busy=%b required 0 1", rx_ready, busy);
        end
        serve_mem(1'b0, 32'h0000_0004, 32'h0, 4'b0001, 32'h0000_00A5);
        recv_tx(8'hA5, 0);
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_done: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_read_half_stall();
        logic [7:0] frame [6];
        frame = '{8'hC1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        serve_mem(1'b0, 32'h0, 32'h0, 4'b0011, 32'h0000_1234);
        // A stray ack during the response must not disturb latched data.
        mem_rdata = 32'h5555_5555;
        mem_ack   = 1'b1;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        recv_tx(8'h34, 5);
        recv_tx(8'h12, 0);
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL half_done: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] frame [6];
        send_byte(8'h55);
        tests_run++;
        if (err !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_pulse: err=%b busy=%b rx_ready=%b required 1 0 1", err, busy, rx_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (err !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: err=%b re=%b we=%b required 0 0 0", err, mem_re, mem_we);
        end
        frame = '{8'hC2, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        serve_mem(1'b0, 32'h0000_0010, 32'h0, 4'b0111, 32'h00C0_FFEE);
        recv_tx(8'hEE, 0);
        recv_tx(8'hFF, 1);
        recv_tx(8'hC0, 0);
        tests_run++;
        if (tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_err_done: tx_valid=%b required 0", tx_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] frame [8];
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_write: busy=%b we=%b rx_ready=%b required 0 0 1", busy, mem_we, rx_ready);
        end
        frame = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h01};
        for (int i = 0; i < 8; i++) send_byte(frame[i]);
        serve_mem(1'b1, 32'h0000_0001, 32'h0000_00FF, 4'b0001, 32'h0);
    endtask

    task automatic test_write_half_msb();
        logic [7:0] frame [9];
        frame = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h0F};
        for (int i = 0; i < 9; i++) send_byte(frame[i]);
        serve_mem(1'b1, 32'h0, 32'h0000_8281, 4'b0011, 32'h0);
    endtask

    task automatic test_reset_mid_resp();
        logic [7:0] frame [6];
        frame = '{8'hC1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        serve_mem(1'b0, 32'h0000_0020, 32'h0, 4'b0011, 32'h0000_BEEF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (tx_valid !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_resp: tx_valid=%b re=%b busy=%b required 0 0 0", tx_valid, mem_re, busy);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame [8];
        frame = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00};
        for (int i = 0; i < 8; i++) send_byte(frame[i]);
        serve_mem(1'b1, 32'h0000_0002, 32'h0000_0011, 4'b0001, 32'h0);
        tests_run++;
        if (rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: rx_ready=%b required 1", rx_ready);
        end
        frame = '{8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h01};
        for (int i = 0; i < 8; i++) send_byte(frame[i]);
        serve_mem(1'b1, 32'h0000_0003, 32'h0000_00A2, 4'b0001, 32'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_write_word();
        test_read_byte();
        test_read_half_stall();
        test_bad_cmd();
        test_reset_mid_write();
        test_write_half_msb();
        test_reset_mid_resp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
